keypad_scanner: RTL



---
 rtl/kbd_pkg.sv | 37 +++
 rtl/keypad_scanner_if.sv | 35 +++
 rtl/key_debounce.sv | 125 ++++++++++++
 rtl/keypad_scanner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
// Shared types and helpers for the keypad scanner:
//   KEY_CODE_W / NO_KEY   : key code width and the idle (no key) code
//   key_cls_e             : per-frame classification (none / single key / multi)
//   scan_state_e          : column scan FSM encoding
//   out_state_e           : report output FSM encoding
//   idx_to_code()         : matrix index -> reported code (index + 1)
// -----------------------------------------------------------------------------
package kbd_pkg;

  localparam int KEY_CODE_W = 8;
  localparam logic [KEY_CODE_W-1:0] NO_KEY = 8'h00;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_KEY   = 2'd1,
    CLS_MULTI = 2'd2
  } key_cls_e;

  typedef enum logic [1:0] {
    SCAN_IDLE = 2'd0,
    SCAN_COL  = 2'd1,
    SCAN_EVAL = 2'd2
  } scan_state_e;

  typedef enum logic [0:0] {
    OUT_IDLE = 1'b0,
    OUT_HOLD = 1'b1
  } out_state_e;

  // Code 0 is reserved for "no key", so every index is reported offset by one.
  function automatic logic [KEY_CODE_W-1:0] idx_to_code(input int unsigned idx);
    idx_to_code = KEY_CODE_W'(idx + 32'd1);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
// Bundles the keypad pins and the key report output.
//   row_in    : matrix rows, pulled up, 0 = pressed on the driven column
//   col_out   : one-hot-low column drive
//   key_data  : key code during a report window, else NO_KEY
//   key_valid : one-cycle pulse at the start of each report window
// Modports: master = scanner side, slave = keypad/consumer side.
// -----------------------------------------------------------------------------
interface keypad_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  import kbd_pkg::*;

  logic [ROWS-1:0]       row_in;
  logic [COLS-1:0]       col_out;
  logic [KEY_CODE_W-1:0] key_data;
  logic                  key_valid;

  modport master (
    input  row_in,
    output col_out,
    output key_data,
    output key_valid
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_data,
    input  key_valid
  );

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Frame-level debouncer and report generator.
//   clk, rst      : clock, async active-high reset
//   i_strobe      : one cycle per completed frame
//   i_cls, i_idx  : classification of that frame and the pressed index
//   o_acc_cls     : currently accepted classification
//   o_report      : one-cycle pulse when a new key press is accepted
//   o_report_idx  : index belonging to o_report
// A MULTI frame is treated as "don't know": it never reports and it does not
// clear the memory of the last accepted key, so KEY->MULTI->same KEY is silent.
// -----------------------------------------------------------------------------
module key_debounce
  import kbd_pkg::*;
#(
  parameter int IDX_W          = 4,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_strobe,
  input  key_cls_e         i_cls,
  input  logic [IDX_W-1:0] i_idx,
  output key_cls_e         o_acc_cls,
  output logic             o_report,
  output logic [IDX_W-1:0] o_report_idx
);

  localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_SCANS);

  key_cls_e         r_cand_cls, w_cand_cls_nxt;
  logic [IDX_W-1:0] r_cand_idx, w_cand_idx_nxt;
  logic [DB_W-1:0]  r_cnt, w_cnt_nxt;
  key_cls_e         r_acc_cls, w_acc_cls_nxt;
  key_cls_e         r_last_cls, w_last_cls_nxt;
  logic [IDX_W-1:0] r_last_idx, w_last_idx_nxt;
  logic             r_report, w_report_nxt;
  logic [IDX_W-1:0] r_report_idx, w_report_idx_nxt;
  logic [IDX_W-1:0] w_idx_norm;
  logic             w_match;

  // Next-state for candidate, counter, accepted state and report strobe.
  always_comb begin
    w_cand_cls_nxt   = r_cand_cls;
    w_cand_idx_nxt   = r_cand_idx;
    w_cnt_nxt        = r_cnt;
    w_acc_cls_nxt    = r_acc_cls;
    w_last_cls_nxt   = r_last_cls;
    w_last_idx_nxt   = r_last_idx;
    w_report_nxt     = 1'b0;
    w_report_idx_nxt = r_report_idx;
    // Index only carries meaning for a single key; zero it otherwise so the
    // candidate compare is a plain equality.
    if (i_cls == CLS_KEY) begin
      w_idx_norm = i_idx;
    end else begin
      w_idx_norm = {IDX_W{1'b0}};
    end
    w_match = (i_cls == r_cand_cls) && (w_idx_norm == r_cand_idx);

    if (i_strobe) begin
      if (w_match) begin
        if (r_cnt == DB_MAX) begin
          w_cnt_nxt = r_cnt;
        end else begin
          w_cnt_nxt = r_cnt + DB_W'(1);
        end
      end else begin
        w_cand_cls_nxt = i_cls;
        w_cand_idx_nxt = w_idx_norm;
        w_cnt_nxt      = DB_W'(1);
      end

      if (w_cnt_nxt == DB_MAX) begin
        w_acc_cls_nxt = w_cand_cls_nxt;
        if ((w_cand_cls_nxt == CLS_KEY) &&
            !((r_last_cls == CLS_KEY) && (r_last_idx == w_cand_idx_nxt))) begin
          w_report_nxt     = 1'b1;
          w_report_idx_nxt = w_cand_idx_nxt;
        end else begin
          w_report_nxt     = 1'b0;
        end
        if (w_cand_cls_nxt == CLS_MULTI) begin
          w_last_cls_nxt = r_last_cls;
        end else begin
          w_last_cls_nxt = w_cand_cls_nxt;
          w_last_idx_nxt = w_cand_idx_nxt;
        end
      end else begin
        w_acc_cls_nxt = r_acc_cls;
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand_cls   <= CLS_NONE;
      r_cand_idx   <= {IDX_W{1'b0}};
      r_cnt        <= {DB_W{1'b0}};
      r_acc_cls    <= CLS_NONE;
      r_last_cls   <= CLS_NONE;
      r_last_idx   <= {IDX_W{1'b0}};
      r_report     <= 1'b0;
      r_report_idx <= {IDX_W{1'b0}};
    end else begin
      r_cand_cls   <= w_cand_cls_nxt;
      r_cand_idx   <= w_cand_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_acc_cls    <= w_acc_cls_nxt;
      r_last_cls   <= w_last_cls_nxt;
      r_last_idx   <= w_last_idx_nxt;
      r_report     <= w_report_nxt;
      r_report_idx <= w_report_idx_nxt;
    end
  end

  assign o_acc_cls    = r_acc_cls;
  assign o_report     = r_report;
  assign o_report_idx = r_report_idx;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a ROWS x COLS active-low key matrix, debounces whole frames and emits
// one key code per accepted press for HOLD_CYCLES cycles.
//   clk, rst : clock, async active-high reset
//   bus      : keypad_scanner_if.master (row_in, col_out, key_data, key_valid)
// Each column is driven for SCAN_DIV cycles; rows are sampled (after a 2-flop
// synchronizer) in the last cycle of each slot. The frame is evaluated in the
// first cycle of the next frame (SCAN_EVAL), which also drives column 0, so
// the frame period stays COLS*SCAN_DIV.
// -----------------------------------------------------------------------------
module keypad_scanner
  import kbd_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int HOLD_CYCLES    = 64
) (
  input  logic clk,
  input  logic rst,
  keypad_scanner_if.master bus
);

  localparam int N      = ROWS * COLS;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

  logic [ROWS-1:0]       r_sync1, r_sync2;
  scan_state_e           r_scan_state, w_scan_nxt;
  logic [COL_W-1:0]      r_col, w_col_nxt;
  logic [SLOT_W-1:0]     r_slot, w_slot_nxt;
  logic [N-1:0]          r_frame, w_frame_nxt;
  logic [COLS-1:0]       r_col_out, w_col_out_nxt;
  logic                  w_eval, w_sample;
  logic                  w_any, w_multi;
  logic [IDX_W-1:0]      w_first_idx;
  key_cls_e              w_cls;
  key_cls_e              w_acc_cls;
  logic                  w_report;
  logic [IDX_W-1:0]      w_report_idx;
  out_state_e            r_out_state, w_out_nxt;
  logic [HOLD_W-1:0]     r_hold, w_hold_nxt;
  logic [KEY_CODE_W-1:0] r_key_data, w_key_data_nxt;
  logic                  r_key_valid, w_key_valid_nxt;

  // Two-flop synchronizer for the asynchronous row pins (idle = pulled up).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= {ROWS{1'b1}};
      r_sync2 <= {ROWS{1'b1}};
    end else begin
      r_sync1 <= bus.row_in;
      r_sync2 <= r_sync1;
    end
  end

  // Scan FSM next-state: column/slot sequencing and frame image accumulation.
  always_comb begin
    w_scan_nxt  = r_scan_state;
    w_col_nxt   = r_col;
    w_slot_nxt  = r_slot;
    w_frame_nxt = r_frame;
    w_eval      = 1'b0;
    w_sample    = 1'b0;
    case (r_scan_state)
      SCAN_IDLE: begin
        w_scan_nxt = SCAN_COL;
        w_col_nxt  = {COL_W{1'b0}};
        w_slot_nxt = {SLOT_W{1'b0}};
      end
      SCAN_EVAL: begin
        // Slot 0 of column 0; the finished frame is consumed and cleared.
        w_eval      = 1'b1;
        w_frame_nxt = {N{1'b0}};
        w_slot_nxt  = SLOT_W'(1);
        w_scan_nxt  = SCAN_COL;
      end
      SCAN_COL: begin
        if (r_slot == SLOT_LAST) begin
          w_sample   = 1'b1;
          w_slot_nxt = {SLOT_W{1'b0}};
          if (r_col == COL_LAST) begin
            w_col_nxt  = {COL_W{1'b0}};
            w_scan_nxt = SCAN_EVAL;
          end else begin
            w_col_nxt  = r_col + COL_W'(1);
            w_scan_nxt = SCAN_COL;
          end
        end else begin
          w_slot_nxt = r_slot + SLOT_W'(1);
        end
      end
      default: begin
        w_scan_nxt = SCAN_IDLE;
        w_col_nxt  = {COL_W{1'b0}};
        w_slot_nxt = {SLOT_W{1'b0}};
      end
    endcase

    // Frame bit row*COLS+col gets OR-merged with the (active-low) row sample.
    for (int b = 0; b < N; b++) begin
      if (w_sample && (r_col == COL_W'(b % COLS)) && !r_sync2[b / COLS]) begin
        w_frame_nxt[b] = 1'b1;
      end else begin
        w_frame_nxt[b] = w_frame_nxt[b];
      end
    end

    if (w_scan_nxt == SCAN_IDLE) begin
      w_col_out_nxt = {COLS{1'b1}};
    end else begin
      w_col_out_nxt = ~(COLS'(1'b1) << w_col_nxt);
    end
  end

  // Scan FSM state and column drive registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_state <= SCAN_IDLE;
      r_col        <= {COL_W{1'b0}};
      r_slot       <= {SLOT_W{1'b0}};
      r_frame      <= {N{1'b0}};
      r_col_out    <= {COLS{1'b1}};
    end else begin
      r_scan_state <= w_scan_nxt;
      r_col        <= w_col_nxt;
      r_slot       <= w_slot_nxt;
      r_frame      <= w_frame_nxt;
      r_col_out    <= w_col_out_nxt;
    end
  end

  // Frame classification: count pressed bits (0, 1, many) and lowest index.
  always_comb begin
    w_any       = 1'b0;
    w_multi     = 1'b0;
    w_first_idx = {IDX_W{1'b0}};
    for (int b = 0; b < N; b++) begin
      if (r_frame[b] && !w_any) begin
        w_first_idx = IDX_W'(b);
      end else begin
        w_first_idx = w_first_idx;
      end
      w_multi = w_multi | (w_any & r_frame[b]);
      w_any   = w_any | r_frame[b];
    end
    if (w_multi) begin
      w_cls = CLS_MULTI;
    end else if (w_any) begin
      w_cls = CLS_KEY;
    end else begin
      w_cls = CLS_NONE;
    end
  end

  key_debounce #(
    .IDX_W          (IDX_W),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .i_strobe     (w_eval),
    .i_cls        (w_cls),
    .i_idx        (w_first_idx),
    .o_acc_cls    (w_acc_cls),
    .o_report     (w_report),
    .o_report_idx (w_report_idx)
  );

  // Output FSM next-state: a report (re)starts the hold window.
  always_comb begin
    w_out_nxt       = r_out_state;
    w_hold_nxt      = r_hold;
    w_key_data_nxt  = r_key_data;
    w_key_valid_nxt = 1'b0;
    if (w_report && (w_acc_cls == CLS_KEY)) begin
      w_out_nxt       = OUT_HOLD;
      w_hold_nxt      = HOLD_W'(1);
      w_key_data_nxt  = idx_to_code(32'(w_report_idx));
      w_key_valid_nxt = 1'b1;
    end else begin
      case (r_out_state)
        OUT_IDLE: begin
          w_key_data_nxt = NO_KEY;
          w_hold_nxt     = {HOLD_W{1'b0}};
        end
        OUT_HOLD: begin
          // r_hold counts the window cycles already shown, including the first.
          if (r_hold == HOLD_W'(HOLD_CYCLES)) begin
            w_out_nxt      = OUT_IDLE;
            w_key_data_nxt = NO_KEY;
            w_hold_nxt     = {HOLD_W{1'b0}};
          end else begin
            w_hold_nxt     = r_hold + HOLD_W'(1);
          end
        end
        default: begin
          w_out_nxt      = OUT_IDLE;
          w_key_data_nxt = NO_KEY;
          w_hold_nxt     = {HOLD_W{1'b0}};
        end
      endcase
    end
  end

  // Output FSM state and registered key outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_state <= OUT_IDLE;
      r_hold      <= {HOLD_W{1'b0}};
      r_key_data  <= NO_KEY;
      r_key_valid <= 1'b0;
    end else begin
      r_out_state <= w_out_nxt;
      r_hold      <= w_hold_nxt;
      r_key_data  <= w_key_data_nxt;
      r_key_valid <= w_key_valid_nxt;
    end
  end

  assign bus.col_out   = r_col_out;
  assign bus.key_data  = r_key_data;
  assign bus.key_valid = r_key_valid;

endmodule
